// File: rtl/dmem_resp.sv
// Data-memory responder for the M stage of the RV32I pipeline.
// Serves byte/halfword/word loads and stores with a fixed number of wait
// states, holding the pipeline in stall until the single response cycle.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no access in flight; accepts a request on the next edge
//   WAIT  | access accepted; down-counter runs to its terminal count (0)
//   RESP  | rsp_valid high for one cycle; pipeline advances on this edge
module dmem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall_m,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  waitCount;
    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] wordIdx;
    logic          accept;
    logic          reqErr;
    logic [3:0]    byteEn;
    logic [31:0]   laneWdata;
    logic [31:0]   memWord;
    logic [7:0]    byteSel;
    logic [15:0]   halfSel;
    logic [31:0]   loadData;
    logic [31:0]   rdataNext;
    logic          unusedAddrBits;

    // Upper address bits are dropped so accesses wrap over the array.
    assign wordIdx        = req_addr[AW+1:2];
    assign unusedAddrBits = ^req_addr[31:AW+2];

    // Gating with reset keeps a request held during reset from reaching memory.
    assign accept  = (state == IDLE) & req_valid & ~reset;
    assign stall_m = req_valid & ~rsp_valid;

    // Classify the request: misalignment and unsupported funct3 codes are errors.
    always_comb begin
        reqErr = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000:  reqErr = 1'b0;
                3'b001:  reqErr = req_addr[0];
                3'b010:  reqErr = (req_addr[1:0] != 2'b00);
                default: reqErr = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: reqErr = 1'b0;
                3'b001, 3'b101: reqErr = req_addr[0];
                3'b010:         reqErr = (req_addr[1:0] != 2'b00);
                default:        reqErr = 1'b1;
            endcase
        end
    end

    // Store lane enables and data replicated onto every lane.
    always_comb begin
        byteEn    = 4'b0000;
        laneWdata = req_wdata;
        case (req_funct3)
            3'b000: begin
                byteEn    = 4'b0001 << req_addr[1:0];
                laneWdata = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                byteEn    = req_addr[1] ? 4'b1100 : 4'b0011;
                laneWdata = {2{req_wdata[15:0]}};
            end
            3'b010: byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    // Load lane selection and sign/zero extension of the addressed word.
    always_comb begin
        memWord = mem[wordIdx];
        case (req_addr[1:0])
            2'd0:    byteSel = memWord[7:0];
            2'd1:    byteSel = memWord[15:8];
            2'd2:    byteSel = memWord[23:16];
            default: byteSel = memWord[31:24];
        endcase
        halfSel = req_addr[1] ? memWord[31:16] : memWord[15:0];
        case (req_funct3)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b010:  loadData = memWord;
            3'b100:  loadData = {24'd0, byteSel};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = 32'd0;
        endcase
        rdataNext = (req_we | reqErr) ? 32'd0 : loadData;
    end

    // Memory array: lane-masked write on the accept edge; never reset.
    always_ff @(posedge clk) begin
        if (accept & req_we & ~reqErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= laneWdata[8*i +: 8];
                end
            end
        end
    end

    // Sequencing FSM with wait-state down-counter and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            waitCount <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        rsp_rdata <= rdataNext;
                        rsp_err   <= reqErr;
                        if (WAIT_CYCLES > 0) begin
                            state     <= WAIT;
                            waitCount <= WAIT_LOAD;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (waitCount == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        waitCount <= waitCount - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: two instances (two wait states and zero wait states),
// directed load/store vectors, scoreboard queues checked by per-instance monitors.
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        reqValid0 = 1'b0, reqWe0 = 1'b0;
    logic [31:0] reqAddr0 = '0, reqWdata0 = '0;
    logic [2:0]  reqFunct30 = '0;
    logic        stall0, rspValid0, rspErr0;
    logic [31:0] rspRdata0;

    logic        reqValid1 = 1'b0, reqWe1 = 1'b0;
    logic [31:0] reqAddr1 = '0, reqWdata1 = '0;
    logic [2:0]  reqFunct31 = '0;
    logic        stall1, rspValid1, rspErr1;
    logic [31:0] rspRdata1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    bit b2bMode = 0;
    bit haveLast1 = 0;
    int lastRsp1 = 0;

    dmem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid0), .req_we(reqWe0), .req_addr(reqAddr0),
        .req_wdata(reqWdata0), .req_funct3(reqFunct30),
        .stall_m(stall0), .rsp_valid(rspValid0), .rsp_rdata(rspRdata0), .rsp_err(rspErr0)
    );

    dmem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid1), .req_we(reqWe1), .req_addr(reqAddr1),
        .req_wdata(reqWdata1), .req_funct3(reqFunct31),
        .stall_m(stall1), .rsp_valid(rspValid1), .rsp_rdata(rspRdata1), .rsp_err(rspErr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the two-wait-state instance.
    always @(negedge clk) begin
        if (rspValid0) begin
            if (q0.size() == 0) begin
                chk("u0_spurious_rsp_valid", 32'(rspValid0), 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("u0_rdata", rspRdata0, e.data);
                chk("u0_err", 32'(rspErr0), 32'(e.err));
                chk("u0_latency", 32'(cyc - e.cyc), 32'd3);
                chk("u0_stall_in_rsp", 32'(stall0), 32'd0);
            end
        end
    end

    // Monitor for the zero-wait-state instance.
    always @(negedge clk) begin
        if (rspValid1) begin
            if (q1.size() == 0) begin
                chk("u1_spurious_rsp_valid", 32'(rspValid1), 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("u1_rdata", rspRdata1, e.data);
                chk("u1_err", 32'(rspErr1), 32'(e.err));
                chk("u1_latency", 32'(cyc - e.cyc), 32'd1);
                if (b2bMode && haveLast1) chk("u1_b2b_spacing", 32'(cyc - lastRsp1), 32'd2);
            end
            haveLast1 = 1;
            lastRsp1 = cyc;
        end
    end

    // Issue one op (called #1 after a rising edge); returns #1 after the response edge.
    task automatic doOp(input bit sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] expData, input bit expErr);
        exp_t e;
        bit   got;
        int   n;
        e.data = expData;
        e.err  = expErr;
        e.cyc  = cyc;
        if (sel) begin
            q1.push_back(e);
            reqValid1 = 1'b1; reqWe1 = we; reqAddr1 = addr; reqWdata1 = wdata; reqFunct31 = f3;
        end else begin
            q0.push_back(e);
            reqValid0 = 1'b1; reqWe0 = we; reqAddr0 = addr; reqWdata0 = wdata; reqFunct30 = f3;
        end
        got = 0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (sel ? rspValid1 : rspValid0) got = 1;
            else chk(sel ? "u1_stall_busy" : "u0_stall_busy", 32'(sel ? stall1 : stall0), 32'd1);
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (sel) reqValid1 = 1'b0;
        else reqValid0 = 1'b0;
    endtask

    initial begin
        // Reset with requests held high
        #2;
        reset = 1'b1;
        reqValid0 = 1'b1; reqAddr0 = 32'h10; reqFunct30 = 3'b010;
        reqValid1 = 1'b1; reqAddr1 = 32'h10; reqFunct31 = 3'b010;
        repeat (2) @(negedge clk);
        chk("rst_u0_rsp_valid", 32'(rspValid0), 32'd0);
        chk("rst_u0_rdata", rspRdata0, 32'd0);
        chk("rst_u0_err", 32'(rspErr0), 32'd0);
        chk("rst_u0_stall", 32'(stall0), 32'd1);
        chk("rst_u1_rsp_valid", 32'(rspValid1), 32'd0);
        chk("rst_u1_stall", 32'(stall1), 32'd1);
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        @(negedge clk);
        chk("idle_u0_stall", 32'(stall0), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Word/byte/half access on the two-wait-state instance
        doOp(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
        doOp(0, 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
        doOp(0, 0, 32'h11, 32'h0, 3'b000, 32'hFFFFFFBE, 0);
        doOp(0, 0, 32'h11, 32'h0, 3'b100, 32'h000000BE, 0);
        doOp(0, 0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 0);
        doOp(0, 0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 0);
        doOp(0, 1, 32'h13, 32'hAAAAAA55, 3'b000, 32'h0, 0);
        doOp(0, 0, 32'h10, 32'h0, 3'b010, 32'h55ADBEEF, 0);
        doOp(0, 1, 32'h10, 32'hFFFF1234, 3'b001, 32'h0, 0);
        doOp(0, 0, 32'h10, 32'h0, 3'b010, 32'h55AD1234, 0);
        doOp(0, 0, 32'h13, 32'h0, 3'b000, 32'h00000055, 0);

        // Error cases leave memory untouched
        doOp(0, 0, 32'h12, 32'h0, 3'b010, 32'h0, 1);
        doOp(0, 1, 32'h11, 32'hFFFFFFFF, 3'b001, 32'h0, 1);
        doOp(0, 0, 32'h11, 32'h0, 3'b101, 32'h0, 1);
        doOp(0, 0, 32'h10, 32'h0, 3'b011, 32'h0, 1);
        doOp(0, 1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'h0, 1);
        doOp(0, 0, 32'h10, 32'h0, 3'b010, 32'h55AD1234, 0);

        // Address wrap at 4*DEPTH_WORDS bytes
        doOp(0, 1, 32'h400, 32'hA5A5A5A5, 3'b010, 32'h0, 0);
        doOp(0, 0, 32'h000, 32'h0, 3'b010, 32'hA5A5A5A5, 0);

        // Reset while a store is in WAIT: store stays committed, no response
        reqValid0 = 1'b1; reqWe0 = 1'b1; reqAddr0 = 32'h20; reqWdata0 = 32'h13579BDF; reqFunct30 = 3'b010;
        @(posedge clk);
        #1;
        reqValid0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rspValid0), 32'd0);
        chk("midrst_rdata", rspRdata0, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        doOp(0, 0, 32'h20, 32'h0, 3'b010, 32'h13579BDF, 0);

        // Zero-wait-state instance: back-to-back byte/half loads
        b2bMode = 1;
        doOp(1, 1, 32'h8, 32'h80FF7F01, 3'b010, 32'h0, 0);
        doOp(1, 0, 32'h8, 32'h0, 3'b000, 32'h00000001, 0);
        doOp(1, 0, 32'h9, 32'h0, 3'b000, 32'h0000007F, 0);
        doOp(1, 0, 32'hA, 32'h0, 3'b000, 32'hFFFFFFFF, 0);
        doOp(1, 0, 32'hB, 32'h0, 3'b000, 32'hFFFFFF80, 0);
        doOp(1, 0, 32'hA, 32'h0, 3'b101, 32'h000080FF, 0);
        doOp(1, 0, 32'h8, 32'h0, 3'b001, 32'h00007F01, 0);
        b2bMode = 0;

        repeat (6) @(negedge clk);
        chk("u0_queue_drained", 32'(q0.size()), 32'd0);
        chk("u1_queue_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
